bw_mac_stage: RTL



---
 rtl/bw_mac_pkg.sv | 56 +++++
 rtl/baugh_wooley.sv | 43 ++++
 rtl/bw_mac_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bw_mac_pkg.sv
// bw_mac_pkg
//   Shared types and helpers for the bw_mac_stage multiply-accumulate slice.
//   - state_t      : control FSM states of the MAC stage
//   - stage_ctrl_t : control half of the s1 stage register (last/valid flags)
//   - sat_res_t    : result of a saturating add (value plus overflow flag)
//   - sat_add()    : signed add clamped to a caller-chosen bit width
package bw_mac_pkg;

  // Widest signed value sat_add() can operate on. Callers sign-extend
  // narrower operands into this width and pass their real width separately.
  localparam int LC_SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // The operand fields of s1 depend on a module parameter, so the
  // operands live in sized registers next to this struct in the top.
  typedef struct packed {
    logic last;
    logic valid;
  } stage_ctrl_t;

  typedef struct packed {
    logic                    sat;
    logic [LC_SAT_MAX_W-1:0] value;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the sum to the signed range
  // of a width-bit number. width must be below LC_SAT_MAX_W so the raw sum
  // cannot itself overflow.
  function automatic sat_res_t sat_add(input logic signed [LC_SAT_MAX_W-1:0] x,
                                       input logic signed [LC_SAT_MAX_W-1:0] y,
                                       input int                             width);
    logic signed [LC_SAT_MAX_W-1:0] sum;
    logic signed [LC_SAT_MAX_W-1:0] hi;
    logic signed [LC_SAT_MAX_W-1:0] lo;
    sat_res_t                       res;
    sum = x + y;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    res.sat   = 1'b0;
    res.value = sum;
    if (sum > hi) begin
      res.sat   = 1'b1;
      res.value = hi;
    end else if (sum < lo) begin
      res.sat   = 1'b1;
      res.value = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/baugh_wooley.sv
// baugh_wooley
//   Combinational signed x signed multiplier using the modified
//   Baugh-Wooley partial-product array: partial products that mix exactly
//   one sign bit are inverted, and the constants 2^n and 2^(2n-1) correct
//   the sum, so the whole array can be added as unsigned bits.
// Ports:
//   a_i [p_width-1:0]   signed multiplicand
//   b_i [p_width-1:0]   signed multiplier
//   p_o [2*p_width-1:0] signed product
module baugh_wooley #(
  parameter int p_width = 8
) (
  input  logic [p_width-1:0]   a_i,
  input  logic [p_width-1:0]   b_i,
  output logic [2*p_width-1:0] p_o
);

  localparam logic [2*p_width-1:0] LC_ONE = {{(2*p_width-1){1'b0}}, 1'b1};

  logic [2*p_width-1:0] sum;
  logic [2*p_width-1:0] term;

  // Sum every weighted partial-product bit, then add the two correction
  // constants; the result wraps naturally to 2*p_width bits.
  always_comb begin
    sum  = '0;
    term = '0;
    for (int i = 0; i < p_width; i++) begin
      for (int j = 0; j < p_width; j++) begin
        term = '0;
        if ((i == p_width - 1) != (j == p_width - 1)) begin
          term[0] = ~(a_i[i] & b_i[j]);
        end else begin
          term[0] = a_i[i] & b_i[j];
        end
        sum = sum + (term << (i + j));
      end
    end
    sum = sum + (LC_ONE << p_width) + (LC_ONE << (2 * p_width - 1));
    p_o = sum;
  end

endmodule

// File: rtl/bw_mac_stage.sv
// bw_mac_stage
//   Streaming signed multiply-accumulate stage. Operand pairs arrive over a
//   valid/ready handshake, are registered into s1 and multiplied by the
//   baugh_wooley multiplier; products are sign-extended and accumulated
//   until a beat flagged last has been folded in, then the dot product and
//   beat count are offered over an output valid/ready handshake.
// Configuration:
//   BW_MAC_SAT_EN defined   : every accumulate step clamps to the signed
//                             p_acc_width range and sat_o reports a clamp
//                             anywhere in the vector.
//   BW_MAC_SAT_EN undefined : accumulation wraps, sat_o is constant 0.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   clear_i      synchronous abort of the vector in progress
//   in_valid_i   operand beat valid
//   in_ready_o   stage can take a beat
//   a_i, b_i     signed operands
//   last_i       final beat of the vector
//   out_valid_o  result valid
//   out_ready_i  downstream takes the result
//   result_o     signed accumulated result
//   count_o      beats in the vector (saturates at all-ones)
//   sat_o        accumulator clamped during this vector
module bw_mac_stage
  import bw_mac_pkg::*;
#(
  parameter int p_width     = 8,
  parameter int p_acc_width = 32,
  parameter int p_cnt_width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [p_width-1:0]     a_i,
  input  logic [p_width-1:0]     b_i,
  input  logic                   last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [p_acc_width-1:0] result_o,
  output logic [p_cnt_width-1:0] count_o,
  output logic                   sat_o
);

  state_t                   state_q, state_d;
  stage_ctrl_t              s1_q;
  logic [p_width-1:0]       s1_a_q, s1_b_q;
  logic [2*p_width-1:0]     prod;
  logic [p_acc_width-1:0]   prod_ext;
  logic [p_acc_width-1:0]   acc_q;
  logic [p_acc_width-1:0]   acc_sum;
  logic                     acc_ovf;
  logic [p_acc_width-1:0]   flush_sum;
  logic                     flush_ovf;
  logic [p_cnt_width-1:0]   cnt_q;
  logic                     sat_q;
  logic [p_acc_width-1:0]   result_q;
  logic [p_cnt_width-1:0]   count_q;
  logic                     out_valid_q;
  logic                     sat_out_q;
  logic                     accept;

  baugh_wooley #(
    .p_width(p_width)
  ) u_mult (
    .a_i(s1_a_q),
    .b_i(s1_b_q),
    .p_o(prod)
  );

  assign prod_ext = p_acc_width'($signed(prod));

  // One accumulate step: acc_q plus the product currently sitting in s1.
`ifdef BW_MAC_SAT_EN
  sat_res_t step_res;

  always_comb begin
    step_res = sat_add(LC_SAT_MAX_W'($signed(acc_q)),
                       LC_SAT_MAX_W'($signed(prod_ext)), p_acc_width);
    acc_sum  = step_res.value[p_acc_width-1:0];
    acc_ovf  = step_res.sat;
  end
`else
  always_comb begin
    acc_sum = acc_q + prod_ext;
    acc_ovf = 1'b0;
  end
`endif

  // The flush step only folds in s1 when it really holds the last beat;
  // this keeps the result sane if the FSM ever reaches flush otherwise.
  always_comb begin
    flush_sum = acc_q;
    flush_ovf = 1'b0;
    if (s1_q.valid && s1_q.last) begin
      flush_sum = acc_sum;
      flush_ovf = acc_ovf;
    end
  end

  // Next state and input ready. Reset and clear both force the stage idle
  // and block input so that an abort always wins over a new beat.
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    if (!rst_ni || clear_i) begin
      state_d = S_ACCUM;
    end else begin
      case (state_q)
        S_ACCUM: begin
          in_ready_o = 1'b1;
          if (in_valid_i && last_i) begin
            state_d = S_FLUSH;
          end
        end
        S_FLUSH: state_d = S_OUT;
        S_OUT: begin
          if (out_ready_i) begin
            state_d = S_ACCUM;
          end
        end
        default: state_d = S_ACCUM;
      endcase
    end
  end

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: s1 capture, accumulation, beat counting and the output
  // register. The output register keeps its contents on clear so only
  // reset zeroes result_o/count_o.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q        <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      result_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      sat_out_q   <= 1'b0;
    end else if (clear_i) begin
      s1_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sat_out_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (s1_q.valid) begin
            acc_q <= acc_sum;
            sat_q <= sat_q | acc_ovf;
          end
          s1_q.valid <= accept;
          if (accept) begin
            s1_q.last <= last_i;
            s1_a_q    <= a_i;
            s1_b_q    <= b_i;
            if (cnt_q != {p_cnt_width{1'b1}}) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          result_q    <= flush_sum;
          count_q     <= cnt_q;
          sat_out_q   <= sat_q | flush_ovf;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
          sat_q       <= 1'b0;
          s1_q        <= '0;
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign count_o     = count_q;
  assign sat_o       = sat_out_q;

endmodule
